mprj_stimulus_regs: RTL and testbench
=====================================

# mprj_stimulus_regs

Memory-mapped stimulus block in the Caravel user project area. The management SoC writes it over the user Wishbone bus. It drives a 16-bit check field on mprj_io[31:16] and a 4-bit status field on mprj_io[35:32], so an external monitor can follow firmware progress. A 16-bit user counter can be stepped, copied into the check field, and read back, which proves a user-output -> memory -> output round trip.

## Interface
- BASE_ADDR, 32'h3000_0000: Wishbone base address. Decode compares adr[31:8] against BASE_ADDR[31:8].
- wb_clk_i  in  1: single clock, rising edge.
- wb_rst_i  in  1: reset, synchronous, active-high.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each: Wishbone classic strobes.
- wbs_sel_i  in  4: byte enables for writes.
- wbs_adr_i  in  32: byte address.
- wbs_dat_i  in  32: write data.
- wbs_ack_o  out  1: transfer acknowledge.
- wbs_dat_o  out  32: read data.
- io_in  in  38: pad inputs, readable.
- io_out  out  38: pad outputs.
- io_oeb  out  38: pad output-enable, active-low.

## Operation
- Register map (offset: name, access, reset value):
  - 0x00 CTRL, RW, reset 0. Bit0 DRIVE enables pad drive. Bit1 SRC selects the check-field source: 0 = CHECK register, 1 = COUNT.
  - 0x04 CHECK, RW, reset 0. Bits [15:0].
  - 0x08 STATUS, RW, reset 0. Bits [3:0].
  - 0x0C COUNT, RW, reset 0. Bits [15:0].
  - 0x10 STEP, WO. Any write does COUNT <= COUNT+1; data is ignored; reads return 0.
  - 0x14 COPY, WO. Any write does CHECK <= COUNT; reads return 0.
  - 0x18 IOIN, RO. Returns {26'b0, io_in[37:32]}, i.e. io_in[37:32] in the low 6 bits.
- Writes honour wbs_sel_i per byte. Bits above a register's width are ignored on write and read as 0.
- Unmapped offsets, and addresses outside BASE_ADDR[31:8]:
  - Inside the base page: acknowledged, read 0, write ignored.
  - Outside the base page: no ack.
- Pad outputs:
  - io_out[31:16] = SRC ? COUNT : CHECK.
  - io_out[35:32] = STATUS.
  - All other io_out bits = 0.
  - io_oeb[35:16] = ~DRIVE.
  - All other io_oeb bits = 1 (inputs).
- COUNT wraps from 0xFFFF to 0x0000 on STEP.
- A direct write to COUNT and a STEP cannot coincide (one transfer per ack). COPY samples COUNT as it stood before that cycle.

## Timing
- A transfer starts when cyc&stb are high and ack is low.
- wbs_ack_o asserts exactly one cycle later, for exactly one cycle.
- The register update (write) and wbs_dat_o (read) are valid in the same cycle as the ack.
- stb held high through the ack cycle does not re-trigger. At most one transfer per two cycles.
- Pad outputs are registered and change the cycle after the write is acknowledged. Latency from a write strobe to a pad change is 2 cycles.
- Reset at any point: all registers 0, wbs_ack_o 0, wbs_dat_o 0, io_out all 0, io_oeb all 1. An in-flight transfer is dropped, with no ack.

## Structure
- Shared package mprj_stimulus_pkg holds:
  - register offset constants (OFS_CTRL … OFS_IOIN);
  - CTRL bit indices;
  - field widths (CHK_W=16, STS_W=4);
  - pad index constants (CHK_LSB=16, STS_LSB=32).
- One sub-module, wb_slave_if, handles the Wishbone handshake and ack generation and emits per-register write strobes and the read mux.
- The top level holds the registers and the pad mapping.

## Test plan
- Reset, then idle → io_oeb = all 1s, io_out = 0, CTRL/CHECK/STATUS/COUNT read 0.
- Write CTRL=1, then CHECK=0xAB40 → io_out[31:16]=0xAB40 and io_oeb[35:16]=0 two cycles after the strobe. A read of CHECK returns 0x0000AB40.
- Write STATUS=0xA, then STATUS=0x5 → io_out[35:32] goes 0xA then 0x5. Writing STATUS with sel=4'b0000 leaves it unchanged.
- Write COUNT=0, STEP ×9, then COPY → CHECK=0x0009 and io_out[31:16]=0x0009. Then write CHECK=0xAB51 → pads show 0xAB51.
- Write COUNT=0xFFFF, STEP, then CTRL=3 → COUNT=0 and the pads show COUNT. Offset 0x3C reads 0 with ack. Address 0x3000_0100 receives no ack.
- Assert reset mid-transfer (stb high, before ack) → no ack, all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/mprj_stimulus_pkg.sv
// Shared constants, types and helpers for the Caravel stimulus register block:
// register offsets, CTRL bit positions, field widths and pad positions.
package mprj_stimulus_pkg;

    localparam logic [7:0] OFS_CTRL   = 8'h00;
    localparam logic [7:0] OFS_CHECK  = 8'h04;
    localparam logic [7:0] OFS_STATUS = 8'h08;
    localparam logic [7:0] OFS_COUNT  = 8'h0C;
    localparam logic [7:0] OFS_STEP   = 8'h10;
    localparam logic [7:0] OFS_COPY   = 8'h14;
    localparam logic [7:0] OFS_IOIN   = 8'h18;

    localparam int CTRL_DRIVE = 0;
    localparam int CTRL_SRC   = 1;

    localparam int CTRL_W = 2;
    localparam int CHK_W  = 16;
    localparam int STS_W  = 4;
    localparam int CNT_W  = 16;
    localparam int IOIN_W = 6;

    localparam int IO_W    = 38;
    localparam int CHK_LSB = 16;
    localparam int STS_LSB = 32;
    localparam int OEB_LSB = 16;
    localparam int OEB_W   = 20;

    typedef struct packed {
        logic ctrl;
        logic check;
        logic status;
        logic count;
        logic step;
        logic copy;
    } wr_strb_t;

    // Merge write data into an existing value byte by byte under the Wishbone select lanes.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mprj_stimulus_regs_wb_slave_if.sv
// Wishbone classic slave front end: page decode, single-cycle-latency ack,
// per-register write strobes and the registered read-data mux.
module wb_slave_if
    import mprj_stimulus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cyc,
    input  logic              stb,
    input  logic              we,
    input  logic [31:0]       adr,
    input  logic [CTRL_W-1:0] ctrl_rd,
    input  logic [CHK_W-1:0]  check_rd,
    input  logic [STS_W-1:0]  status_rd,
    input  logic [CNT_W-1:0]  count_rd,
    input  logic [IOIN_W-1:0] ioin_rd,
    output wr_strb_t          wr_strb,
    output logic              ack_o,
    output logic [31:0]       dat_o
);

    logic        ack_q;
    logic        ack_d;
    logic [31:0] dat_q;
    logic [31:0] dat_d;
    logic        page_hit_s;
    logic        start_s;
    logic [31:0] rd_mux_s;

    // Decode, start detection, write strobes and read mux.
    always_comb begin
        page_hit_s = (adr[31:8] == BASE_ADDR[31:8]);
        // ack_q blocks a held strobe from starting a second transfer in the ack cycle
        start_s    = cyc && stb && !ack_q && page_hit_s;

        case (adr[7:0])
            OFS_CTRL:   rd_mux_s = {{(32-CTRL_W){1'b0}}, ctrl_rd};
            OFS_CHECK:  rd_mux_s = {{(32-CHK_W){1'b0}}, check_rd};
            OFS_STATUS: rd_mux_s = {{(32-STS_W){1'b0}}, status_rd};
            OFS_COUNT:  rd_mux_s = {{(32-CNT_W){1'b0}}, count_rd};
            OFS_IOIN:   rd_mux_s = {{(32-IOIN_W){1'b0}}, ioin_rd};
            default:    rd_mux_s = 32'h0000_0000;
        endcase

        wr_strb = '0;
        if (start_s && we) begin
            case (adr[7:0])
                OFS_CTRL:   wr_strb.ctrl   = 1'b1;
                OFS_CHECK:  wr_strb.check  = 1'b1;
                OFS_STATUS: wr_strb.status = 1'b1;
                OFS_COUNT:  wr_strb.count  = 1'b1;
                OFS_STEP:   wr_strb.step   = 1'b1;
                OFS_COPY:   wr_strb.copy   = 1'b1;
                default:    wr_strb        = '0;
            endcase
        end else begin
            wr_strb = '0;
        end

        ack_d = start_s;
        dat_d = (start_s && !we) ? rd_mux_s : 32'h0000_0000;
    end

    // Ack and read-data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
            dat_q <= 32'h0000_0000;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
        end
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/mprj_stimulus_regs.sv
// Stimulus register block: CTRL/CHECK/STATUS/COUNT registers behind Wishbone,
// with registered mapping of the check and status fields onto the user pads.
module mprj_stimulus_regs
    import mprj_stimulus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [IO_W-1:0] io_in,
    output logic [IO_W-1:0] io_out,
    output logic [IO_W-1:0] io_oeb
);

    wr_strb_t          wr_s;
    logic [CTRL_W-1:0] ctrl_q,   ctrl_d;
    logic [CHK_W-1:0]  check_q,  check_d;
    logic [STS_W-1:0]  status_q, status_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [IO_W-1:0]   io_out_q, io_out_d;
    logic [IO_W-1:0]   io_oeb_q, io_oeb_d;
    logic              unused_io_in_s;

    assign unused_io_in_s = ^io_in[31:0];

    wb_slave_if #(
        .BASE_ADDR (BASE_ADDR)
    ) u_wb_slave_if (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .cyc       (wbs_cyc_i),
        .stb       (wbs_stb_i),
        .we        (wbs_we_i),
        .adr       (wbs_adr_i),
        .ctrl_rd   (ctrl_q),
        .check_rd  (check_q),
        .status_rd (status_q),
        .count_rd  (count_q),
        .ioin_rd   (io_in[IO_W-1:32]),
        .wr_strb   (wr_s),
        .ack_o     (wbs_ack_o),
        .dat_o     (wbs_dat_o)
    );

    // Next-state of the registers and the pad images they drive.
    always_comb begin
        ctrl_d   = wr_s.ctrl   ? CTRL_W'(byte_merge(32'(ctrl_q),   wbs_dat_i, wbs_sel_i)) : ctrl_q;
        status_d = wr_s.status ? STS_W'(byte_merge(32'(status_q),  wbs_dat_i, wbs_sel_i)) : status_q;

        // COPY takes COUNT as it stood before this edge
        if (wr_s.copy) begin
            check_d = count_q;
        end else if (wr_s.check) begin
            check_d = CHK_W'(byte_merge(32'(check_q), wbs_dat_i, wbs_sel_i));
        end else begin
            check_d = check_q;
        end

        if (wr_s.count) begin
            count_d = CNT_W'(byte_merge(32'(count_q), wbs_dat_i, wbs_sel_i));
        end else if (wr_s.step) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end

        io_out_d = '0;
        io_out_d[CHK_LSB +: CHK_W] = ctrl_q[CTRL_SRC] ? count_q : check_q;
        io_out_d[STS_LSB +: STS_W] = status_q;

        io_oeb_d = '1;
        io_oeb_d[OEB_LSB +: OEB_W] = {OEB_W{~ctrl_q[CTRL_DRIVE]}};
    end

    // Register and pad state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl_q   <= '0;
            check_q  <= '0;
            status_q <= '0;
            count_q  <= '0;
            io_out_q <= '0;
            io_oeb_q <= '1;
        end else begin
            ctrl_q   <= ctrl_d;
            check_q  <= check_d;
            status_q <= status_d;
            count_q  <= count_d;
            io_out_q <= io_out_d;
            io_oeb_q <= io_oeb_d;
        end
    end

    assign io_out = io_out_q;
    assign io_oeb = io_oeb_q;

endmodule

// File: tb/tb_mprj_stimulus_regs.sv
// Self-checking bench for mprj_stimulus_regs: directed plan steps followed by
// randomized Wishbone traffic scored against a register-map reference model.
module tb_mprj_stimulus_regs;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic        ack;
    logic [31:0] dat_o;
    logic [37:0] io_in, io_out, io_oeb;

    int checks = 0;
    int errors = 0;

    int unsigned m_ctrl, m_check, m_status, m_count;
    logic [37:0] pad_at_ack;

    mprj_stimulus_regs dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_i),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned merge(input int unsigned old_v, input int unsigned new_v,
                                          input logic [3:0] s, input int unsigned wmask);
        int unsigned m;
        m = 32'd0;
        for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
        return ((old_v & ~m) | (new_v & m)) & wmask;
    endfunction

    function automatic void model_write(input logic [7:0] ofs, input int unsigned d, input logic [3:0] s);
        case (ofs)
            8'h00: m_ctrl   = merge(m_ctrl, d, s, 32'h3);
            8'h04: m_check  = merge(m_check, d, s, 32'hFFFF);
            8'h08: m_status = merge(m_status, d, s, 32'hF);
            8'h0C: m_count  = merge(m_count, d, s, 32'hFFFF);
            8'h10: m_count  = (m_count + 32'd1) % 32'd65536;
            8'h14: m_check  = m_count;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] ofs);
        case (ofs)
            8'h00:   return m_ctrl;
            8'h04:   return m_check;
            8'h08:   return m_status;
            8'h0C:   return m_count;
            8'h18:   return {26'd0, io_in[37:32]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [63:0] exp_out();
        longint unsigned v;
        v = (((m_ctrl >> 1) & 32'd1) != 32'd0) ? longint'(m_count) : longint'(m_check);
        return (v * 64'd65536) + (longint'(m_status) * 64'h1_0000_0000);
    endfunction

    function automatic logic [63:0] exp_oeb();
        logic [63:0] all;
        all = (64'd1 << 38) - 64'd1;
        return ((m_ctrl & 32'd1) != 32'd0) ? (all & ~(64'hF_FFFF << 16)) : all;
    endfunction

    task automatic check_pads(input string tag);
        chk({tag, "_io_out"}, io_out, exp_out());
        chk({tag, "_io_oeb"}, io_oeb, exp_oeb());
    endtask

    // One bus transfer; entered and left 1 time unit after a rising edge.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                        input bit hold, output bit acked, output logic [31:0] rdata);
        int n;
        n = 0;
        acked = 1'b0;
        rdata = 32'd0;
        adr = a; we = w; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
        while (n < 4 && !acked) begin
            @(posedge clk); #1;
            n++;
            if (ack) acked = 1'b1;
        end
        if (acked) begin
            rdata = dat_o;
            pad_at_ack = io_out;
            chk("ack_latency", 64'(n), 64'd1);
            if (hold) begin
                @(posedge clk); #1;
                cyc = 1'b0; stb = 1'b0;
            end else begin
                cyc = 1'b0; stb = 1'b0;
                @(posedge clk); #1;
            end
            chk("ack_single", 64'(ack), 64'd0);
        end else begin
            cyc = 1'b0; stb = 1'b0;
            @(posedge clk); #1;
        end
        we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] ofs, input logic [31:0] d, input logic [3:0] s, input bit hold);
        bit a;
        logic [31:0] r;
        xfer(BASE | 32'(ofs), 1'b1, d, s, hold, a, r);
        chk("wr_ack", 64'(a), 64'd1);
        model_write(ofs, d, s);
        check_pads("wr");
    endtask

    task automatic rd(input logic [7:0] ofs);
        bit a;
        logic [31:0] r;
        xfer(BASE | 32'(ofs), 1'b0, 32'd0, 4'hF, 1'b0, a, r);
        chk("rd_ack", 64'(a), 64'd1);
        chk($sformatf("rd_%02h", ofs), r, model_read(ofs));
    endtask

    initial begin
        bit a;
        logic [31:0] r;
        logic [7:0] ofs_tbl [10];
        logic [7:0] o;
        ofs_tbl = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h3C, 8'h80};

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'd0; dat_i = 32'd0; io_in = 38'h15_0000_0000;
        m_ctrl = 0; m_check = 0; m_status = 0; m_count = 0;
        pad_at_ack = 38'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Reset state
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_dat", dat_o, 64'd0);
        check_pads("rst");
        rd(8'h00); rd(8'h04); rd(8'h08); rd(8'h0C);

        // Drive enable and check field, with 2-cycle pad latency
        wr(8'h00, 32'h1, 4'hF, 1'b0);
        wr(8'h04, 32'hAB40, 4'hF, 1'b0);
        chk("pad_not_yet", pad_at_ack, 64'd0);
        chk("chk_pad_val", io_out[31:16], 64'hAB40);
        chk("chk_oeb_val", io_oeb[35:16], 64'h0);
        rd(8'h04);

        // Status sequence and empty byte-select
        wr(8'h08, 32'hA, 4'hF, 1'b0);
        chk("sts_a", io_out[35:32], 64'hA);
        wr(8'h08, 32'h5, 4'hF, 1'b0);
        chk("sts_5", io_out[35:32], 64'h5);
        wr(8'h08, 32'hF, 4'h0, 1'b0);
        chk("sts_sel0", io_out[35:32], 64'h5);

        // Step/copy round trip; some steps hold stb through the ack
        wr(8'h0C, 32'h0, 4'hF, 1'b0);
        for (int i = 0; i < 9; i++) wr(8'h10, $urandom, 4'hF, (i % 2) == 1);
        wr(8'h14, 32'h0, 4'hF, 1'b0);
        rd(8'h04);
        chk("copy_pad", io_out[31:16], 64'h0009);
        wr(8'h04, 32'hAB51, 4'hF, 1'b0);
        chk("chk_ab51", io_out[31:16], 64'hAB51);

        // Counter wrap and COUNT as source
        wr(8'h0C, 32'hFFFF, 4'hF, 1'b0);
        wr(8'h10, 32'h0, 4'hF, 1'b0);
        wr(8'h00, 32'h3, 4'hF, 1'b0);
        rd(8'h0C);
        chk("wrap_pad", io_out[31:16], 64'h0);

        // Unmapped offset inside the page, then an address outside it
        rd(8'h3C);
        xfer(32'h3000_0100, 1'b0, 32'd0, 4'hF, 1'b0, a, r);
        chk("off_page_noack", 64'(a), 64'd0);
        xfer(32'h3000_0104, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, a, r);
        chk("off_page_wr_noack", 64'(a), 64'd0);
        rd(8'h04);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            io_in = {$urandom, $urandom};
            o = ofs_tbl[$urandom_range(0, 9)];
            if ($urandom_range(0, 1) == 0) begin
                rd(o);
            end else begin
                wr(o, $urandom, 4'($urandom), $urandom_range(0, 1) == 1);
            end
            rd(8'h18);
        end

        // Reset while a transfer is in flight
        adr = BASE | 32'h4; we = 1'b1; dat_i = 32'h1234; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ack", 64'(ack), 64'd0);
        chk("midrst_dat", dat_o, 64'd0);
        chk("midrst_out", io_out, 64'd0);
        chk("midrst_oeb", io_oeb, 64'h3F_FFFF_FFFF);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        m_ctrl = 0; m_check = 0; m_status = 0; m_count = 0;
        @(posedge clk); #1;
        chk("postrst_ack", 64'(ack), 64'd0);
        rd(8'h00); rd(8'h04); rd(8'h08); rd(8'h0C);
        check_pads("postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
